// File: rtl/fdiv_ctrl.sv
// rtl/fdiv_ctrl.sv - IEEE-754 single divide controller around an iterative mantissa divider
// Optional feature macro: FDIV_EXC_FLAGS_EN adds the registered exc_flags {NV,DZ,OF,UF,NX} output.
module fdiv_ctrl #(
  parameter int DRAIN_CYC = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_q,
  output logic [23:0] div_a,
  output logic [23:0] div_b,
  output logic        div_fdiv,
  output logic        div_en,
  input  logic        div_busy,
  input  logic [31:0] div_q
`ifdef FDIV_EXC_FLAGS_EN
  ,
  output logic [4:0]  exc_flags
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_PACK, S_DONE} state_t;

  // The busy-low WAIT cycle already counts as the first drain cycle.
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYC - 1);

  state_t      state, state_nx;
  logic        sign_r, spec_r, sp_nv_r, sp_dz_r, sp_ainf_r, first_r;
  logic [7:0]  ea_r, eb_r, cnt_r;
  logic [31:0] q_r;

  logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic        cls_special, cls_nv, cls_dz, accept, to_pack;
  logic [9:0]  e_base, e_norm, e_fin;
  logic        hi, grd, stk, rnd_up, of, uf;
  logic [22:0] frac;
  logic [23:0] rnd;
  logic [31:0] norm_q, sp_q;

  // Operand classification; denormals (exponent 0) are treated as zero.
  always_comb begin
    a_zero      = (in_a[30:23] == 8'h00);
    a_inf       = (in_a[30:23] == 8'hFF) && (in_a[22:0] == 23'd0);
    a_nan       = (in_a[30:23] == 8'hFF) && (in_a[22:0] != 23'd0);
    b_zero      = (in_b[30:23] == 8'h00);
    b_inf       = (in_b[30:23] == 8'hFF) && (in_b[22:0] == 23'd0);
    b_nan       = (in_b[30:23] == 8'hFF) && (in_b[22:0] != 23'd0);
    cls_special = a_zero | a_inf | a_nan | b_zero | b_inf | b_nan;
    cls_nv      = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
    cls_dz      = b_zero & ~a_zero & ~a_inf & ~a_nan;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state and handshake/divider control outputs
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    div_fdiv  = 1'b0;
    div_en    = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        // A divider still busy from a discarded op must finish before a new issue.
        in_ready = ~div_busy;
        if (in_valid && !div_busy) state_nx = cls_special ? S_PACK : S_ISSUE;
      end
      S_ISSUE: begin
        div_fdiv = 1'b1;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        div_en = 1'b1;
        // Busy is registered in the divider, so the first WAIT cycle is ignored.
        if (!first_r && !div_busy) state_nx = (DRAIN_LAST == 8'd0) ? S_PACK : S_DRAIN;
      end
      S_DRAIN: begin
        div_en = 1'b1;
        if (cnt_r >= DRAIN_LAST) state_nx = S_PACK;
      end
      S_PACK: state_nx = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign accept  = (state == S_IDLE) && in_valid && in_ready;
  assign to_pack = ((state == S_WAIT) || (state == S_DRAIN)) && (state_nx == S_PACK);

  // Normalize, round-to-nearest-even and range-check the divider quotient
  always_comb begin
    e_base = {2'b00, ea_r} - {2'b00, eb_r} + 10'd127;
    hi     = q_r[31] | q_r[30];
    if (hi) begin
      frac   = q_r[29:7];
      grd    = q_r[6];
      stk    = |q_r[5:0];
      e_norm = e_base;
    end else begin
      frac   = q_r[28:6];
      grd    = q_r[5];
      stk    = |q_r[4:0];
      e_norm = e_base - 10'd1;
    end
    rnd_up = grd & (stk | frac[0]);
    rnd    = {1'b0, frac} + {23'd0, rnd_up};
    e_fin  = e_norm + {9'd0, rnd[23]};
    of     = ~e_fin[9] && (e_fin[8:0] >= 9'd255);
    uf     = e_fin[9] || (e_fin == 10'd0);
    if (of)      norm_q = {sign_r, 8'hFF, 23'd0};
    else if (uf) norm_q = {sign_r, 31'd0};
    else         norm_q = {sign_r, e_fin[7:0], rnd[22:0]};
    if (sp_nv_r)                  sp_q = 32'h7FC00000;
    else if (sp_dz_r | sp_ainf_r) sp_q = {sign_r, 8'hFF, 23'd0};
    else                          sp_q = {sign_r, 31'd0};
  end

  // Operand capture, drain counting, quotient capture and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_r    <= 1'b0;
      spec_r    <= 1'b0;
      sp_nv_r   <= 1'b0;
      sp_dz_r   <= 1'b0;
      sp_ainf_r <= 1'b0;
      first_r   <= 1'b0;
      ea_r      <= 8'd0;
      eb_r      <= 8'd0;
      cnt_r     <= 8'd0;
      q_r       <= 32'd0;
      div_a     <= 24'd0;
      div_b     <= 24'd0;
      out_q     <= 32'd0;
    end else begin
      first_r <= (state == S_ISSUE);
      if (accept) begin
        sign_r    <= in_a[31] ^ in_b[31];
        ea_r      <= in_a[30:23];
        eb_r      <= in_b[30:23];
        div_a     <= {1'b1, in_a[22:0]};
        div_b     <= {1'b1, in_b[22:0]};
        spec_r    <= cls_special;
        sp_nv_r   <= cls_nv;
        sp_dz_r   <= cls_dz;
        sp_ainf_r <= a_inf;
      end
      if (state == S_WAIT)       cnt_r <= 8'd1;
      else if (state == S_DRAIN) cnt_r <= cnt_r + 8'd1;
      if (to_pack) q_r <= div_q;
      if (state == S_PACK) out_q <= spec_r ? sp_q : norm_q;
    end
  end

`ifdef FDIV_EXC_FLAGS_EN
  // Flags are captured together with out_q so they share its valid window
  always_ff @(posedge clk) begin
    if (rst) exc_flags <= 5'd0;
    else if (state == S_PACK)
      exc_flags <= spec_r ? {sp_nv_r, sp_dz_r, 3'b000}
                          : {2'b00, of, uf, of | uf | grd | stk};
  end
`endif

endmodule
